mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream controller for the team's 4:1 mux (inputs d0..d3, selects s0/s1, output y).
- Drives s1/s0 to step through an enabled subset of the four channels and holds each channel for a programmable dwell.
- Samples mux output y on the last dwell cycle of each channel and assembles one 4-bit frame per complete scan.
- Supports single-shot or continuous scanning, with a stop/abort input.

Parameters:
DW, 8, width of dwell count input; per-channel hold is 1..2^DW-1 cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
stop  input  1  abort request; highest priority
cont  input  1  latched at start; 1 = rescan continuously, 0 = single frame
en_mask  input  4  channel enable, bit i = channel i; latched at start
dwell  input  DW  hold cycles per channel, latched at start; 0 treated as 1
y  input  1  output of downstream 4:1 mux
s0  output  1  mux select LSB (registered)
s1  output  1  mux select MSB (registered)
sample  output  4  last completed frame; bit i = y captured on channel i, 0 for disabled channels
sample_valid  output  1  one-cycle pulse when sample updates
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse when start is given with en_mask == 0

Behaviour:
- Reset values (asynchronous, immediate on rst=1): s0=0, s1=0, sample=0, sample_valid=0, busy=0, err=0.
- Reset also clears the following to 0: state=IDLE, channel index, hold counter, shadow frame, latched mask/dwell/cont.
- rst mid-scan aborts the scan. No sample_valid is produced.
- State IDLE:
  - start=1, stop=0, en_mask!=0:
    - Latch en_mask, cont, and D=max(dwell,1).
    - Clear the shadow frame.
    - Set ch = lowest set bit of en_mask.
    - Next cycle {s1,s0}=ch, busy=1, hold counter=D-1, go to HOLD.
  - start=1, en_mask==0: err=1 for one cycle, remain IDLE.
- State HOLD:
  - {s1,s0} is held constant and the counter decrements each cycle.
  - On the cycle the counter is 0, capture y into shadow[ch]. This gives D-1 settle cycles; y is combinational from s0/s1.
  - After capture, find the next enabled channel above ch.
    - If one exists: ch = that channel, {s1,s0} updated next cycle, counter=D-1.
    - If none (scan wraps past the highest enabled channel): sample<=shadow with the capture included, and sample_valid=1 the next cycle. Then:
      - cont=1: ch = lowest enabled channel, shadow cleared, continue HOLD without an idle gap.
      - cont=0: go IDLE, busy=0, s0=s1=0.
- Timing: start accepted at edge N. Selects valid at N+1. First capture at edge N+D.
- Frame period: frame period = (number of enabled channels) × D cycles. With a single enabled channel, sample_valid pulses every D cycles in continuous mode.
- stop=1 in HOLD: go IDLE next cycle, s0=s1=0, busy=0. The shadow frame is discarded, and sample keeps its previous value. This applies even if stop coincides with the frame-completion capture: stop wins and there is no sample_valid.
- stop and start together in IDLE: start ignored.
- start while busy: ignored. The latched mask, dwell, and cont are unchanged until the next IDLE start.
- Input changes to en_mask, dwell, and cont during a scan have no effect.
- Disabled channels are never selected and read 0 in sample.

Test Plan:
- Mux data d0=1,d1=0,d2=1,d3=1; mask=4'b1111, dwell=3, cont=0; pulse start -> selects 0,1,2,3 each held 3 cycles; sample=4'b1101; one sample_valid 12 cycles after start; busy drops the following cycle.
- Same data, mask=4'b1010, dwell=0 -> D=1; selects 1,3 one cycle each; sample=4'b1000; sample_valid 2 cycles after start.
- mask=4'b0100, dwell=2, cont=1 -> s1s0 stuck at 2'b10; sample_valid every 2 cycles; sample=4'b0100. Toggling d2 to 0 gives sample=4'b0000 on the next frame.
- start with mask=0 -> err pulses once; busy stays 0; no select change.
- Continuous full scan, dwell=4; assert stop on the final capture cycle -> no sample_valid; sample retains the prior frame; s0=s1=0 and busy=0 next cycle.
- Assert rst asynchronously mid-HOLD -> all outputs 0 immediately. A new start after release restarts from the lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a downstream 4:1 mux: steps through enabled channels,
// holds each for a dwell period, and captures y into a 4-bit frame per scan.
//
// state | meaning
// IDLE  | selects parked at 0, waiting for start
// HOLD  | holding a channel; capture y when the hold counter reaches 0
module mux_scan_sequencer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [3:0]    en_mask,
    input  logic [DW-1:0] dwell,
    input  logic          y,
    output logic          s0,
    output logic          s1,
    output logic [3:0]    sample,
    output logic          sample_valid,
    output logic          busy,
    output logic          err
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [DW-1:0] one = DW'(1);

    state_t        state, state_nx;
    logic [1:0]    ch, ch_nx, sel, sel_nx;
    logic [DW-1:0] cnt, cnt_nx, dl, dl_nx, d_in;
    logic [3:0]    shadow, shadow_nx, mask_l, mask_nx, sample_nx, captured;
    logic          cont_l, cont_nx, valid_nx, err_nx;
    logic [1:0]    low_start, low_latched, above;
    logic          above_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= '0;
            sel          <= '0;
            cnt          <= '0;
            dl           <= '0;
            shadow       <= '0;
            mask_l       <= '0;
            cont_l       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nx;
            ch           <= ch_nx;
            sel          <= sel_nx;
            cnt          <= cnt_nx;
            dl           <= dl_nx;
            shadow       <= shadow_nx;
            mask_l       <= mask_nx;
            cont_l       <= cont_nx;
            sample       <= sample_nx;
            sample_valid <= valid_nx;
            err          <= err_nx;
        end
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = (state == HOLD);

    // Channel search helpers: lowest enabled channel and next enabled above ch
    always_comb begin
        low_start   = '0;
        low_latched = '0;
        above       = '0;
        above_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (en_mask[i]) low_start = 2'(i);
            if (mask_l[i]) low_latched = 2'(i);
            if (mask_l[i] && (2'(i) > ch)) begin
                above       = 2'(i);
                above_found = 1'b1;
            end
        end
    end

    assign d_in     = (dwell == '0) ? one : dwell;
    assign captured = shadow | ({3'b000, y} << ch);

    always_comb begin
        state_nx  = state;
        ch_nx     = ch;
        sel_nx    = sel;
        cnt_nx    = cnt;
        dl_nx     = dl;
        shadow_nx = shadow;
        mask_nx   = mask_l;
        cont_nx   = cont_l;
        sample_nx = sample;
        valid_nx  = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (en_mask == 4'b0000) begin
                        err_nx = 1'b1;
                    end else begin
                        mask_nx   = en_mask;
                        cont_nx   = cont;
                        dl_nx     = d_in;
                        shadow_nx = '0;
                        ch_nx     = low_start;
                        sel_nx    = low_start;
                        cnt_nx    = d_in - one;
                        state_nx  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_nx  = IDLE;
                    sel_nx    = '0;
                    shadow_nx = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - one;
                end else if (above_found) begin
                    ch_nx     = above;
                    sel_nx    = above;
                    shadow_nx = captured;
                    cnt_nx    = dl - one;
                end else begin
                    // Frame complete: publish, then either rescan or park
                    sample_nx = captured;
                    valid_nx  = 1'b1;
                    shadow_nx = '0;
                    if (cont_l) begin
                        ch_nx  = low_latched;
                        sel_nx = low_latched;
                        cnt_nx = dl - one;
                    end else begin
                        state_nx = IDLE;
                        sel_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: time-indexed scan model checked every cycle,
// plus directed scenarios with hand-computed frames and latencies.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [3:0] en_mask = 4'b0000;
    logic [7:0] dwell = 8'd0;
    logic [3:0] dvec = 4'b0000;
    logic       y, s0, s1, sample_valid, busy, err;
    logic [3:0] sample;

    int errors = 0;
    int checks = 0;

    assign y = dvec[{s1, s0}];

    mux_scan_sequencer #(.DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .en_mask(en_mask), .dwell(dwell), .y(y),
        .s0(s0), .s1(s1), .sample(sample), .sample_valid(sample_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scan position derived from cycles elapsed since the accepting edge
    bit         m_active;
    int         m_chans[4];
    int         m_n, m_d, m_k;
    bit         m_cont;
    logic [3:0] m_shadow, exp_sample;
    logic [1:0] exp_sel;
    bit         exp_valid, exp_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_shadow = '0; exp_sample = '0;
            exp_valid = 0; exp_err = 0; m_k = 0; m_n = 1; m_d = 1;
        end else begin
            exp_valid = 0;
            exp_err   = 0;
            if (!m_active) begin
                if (start && !stop) begin
                    if (en_mask == 4'b0000) exp_err = 1;
                    else begin
                        m_n = 0;
                        for (int i = 0; i < 4; i++)
                            if (en_mask[i]) begin m_chans[m_n] = i; m_n++; end
                        m_d = (dwell == 0) ? 1 : int'(dwell);
                        m_cont = cont; m_k = 0; m_active = 1; m_shadow = '0;
                    end
                end
            end else if (stop) begin
                m_active = 0; m_shadow = '0;
            end else begin
                m_k++;
                if (m_k % m_d == 0) begin
                    int j, c;
                    j = m_k / m_d;
                    c = m_chans[(j - 1) % m_n];
                    m_shadow[c] = dvec[c];
                    if (j % m_n == 0) begin
                        exp_sample = m_shadow; exp_valid = 1; m_shadow = '0;
                        if (!m_cont) m_active = 0;
                    end
                end
            end
        end
        exp_sel = m_active ? 2'(m_chans[(m_k % (m_n * m_d)) / m_d]) : 2'b00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("sel", {30'd0, s1, s0}, {30'd0, exp_sel});
            chk("busy", busy, m_active);
            chk("sample", sample, exp_sample);
            chk("sample_valid", sample_valid, exp_valid);
            chk("err", err, exp_err);
        end
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sample_valid && cyc < 300);
    endtask

    task automatic do_start(input logic [3:0] m, input logic [7:0] d, input logic c);
        en_mask = m; dwell = d; cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int cyc;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sel", {30'd0, s1, s0}, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sample", sample, 0);

        // Full single scan, dwell 3
        dvec = 4'b1101;
        do_start(4'b1111, 8'd3, 1'b0);
        wait_valid(cyc);
        chk("full_latency", cyc, 12);
        chk("full_frame", sample, 4'b1101);
        chk("full_busy_after", busy, 0);
        repeat (2) @(negedge clk);

        // Sparse mask, dwell 0 behaves as 1
        do_start(4'b1010, 8'd0, 1'b0);
        wait_valid(cyc);
        chk("sparse_latency", cyc, 2);
        chk("sparse_frame", sample, 4'b1000);
        repeat (2) @(negedge clk);

        // Single channel continuous
        do_start(4'b0100, 8'd2, 1'b1);
        chk("single_sel", {30'd0, s1, s0}, 2);
        wait_valid(cyc);
        chk("single_first", cyc, 2);
        chk("single_frame", sample, 4'b0100);
        en_mask = 4'b0011; dwell = 8'd7; start = 1'b1;
        wait_valid(cyc);
        start = 1'b0;
        chk("single_period", cyc, 2);
        dvec[2] = 1'b0;
        wait_valid(cyc);
        chk("single_period2", cyc, 2);
        chk("single_frame_d2low", sample, 4'b0000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("single_stopped", busy, 0);
        @(negedge clk);

        // Empty mask
        do_start(4'b0000, 8'd3, 1'b0);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_cleared", err, 0);

        // Continuous full scan, stop on final capture of second frame
        dvec = 4'b0110;
        do_start(4'b1111, 8'd4, 1'b1);
        wait_valid(cyc);
        chk("cont_latency", cyc, 16);
        chk("cont_frame", sample, 4'b0110);
        dvec = 4'b1001;
        repeat (15) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_no_valid", sample_valid, 0);
        chk("stop_sample_kept", sample, 4'b0110);
        chk("stop_busy", busy, 0);
        chk("stop_sel", {30'd0, s1, s0}, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-hold
        do_start(4'b1100, 8'd5, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", {30'd0, s1, s0}, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sample", sample, 0);
        chk("arst_valid", sample_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(4'b1100, 8'd1, 1'b0);
        chk("restart_sel", {30'd0, s1, s0}, 2);
        wait_valid(cyc);
        chk("restart_latency", cyc, 2);
        chk("restart_frame", sample, 4'b1000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
